// File: rtl/sram_req_arbiter.sv
// Two-requester (fetch/data) arbiter onto one sram-like bus, with an in-order ID FIFO for response routing.
// Optional ARB_RR_EN: alternate priority when both request in IDLE; default is fixed data-over-inst.
module sram_req_arbiter #(
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_cache,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_cache,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_cache,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        arb_err
);

  localparam int unsigned PW = $clog2(OUTST_DEPTH);
  localparam int unsigned CW = $clog2(OUTST_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e                 state_q, state_d;
  logic [OUTST_DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d;

  logic win_data, sel_data, sel_req;
  logic full, empty, push, pop, head;

  assign full  = (count_q == CW'(OUTST_DEPTH));
  assign empty = (count_q == '0);

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // last_grant holds the id of the most recent accepted requester; the other one wins a tie
  always_comb win_data = data_req && (!inst_req || !last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (push) last_grant_d = sel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b0;
    else       last_grant_q <= last_grant_d;
  end
`else
  always_comb win_data = data_req;
`endif

  always_comb begin
    sel_data = win_data;
    case (state_q)
      LOCK_I:  sel_data = 1'b0;
      LOCK_D:  sel_data = 1'b1;
      default: sel_data = win_data;
    endcase
  end

  assign sel_req = sel_data ? data_req : inst_req;
  assign bus_req = sel_req && !full;
  assign push    = bus_req && bus_addr_ok;
  assign pop     = bus_data_ok && !empty;
  assign head    = id_q[rd_ptr_q];

  assign bus_wr    = sel_data ? data_wr    : inst_wr;
  assign bus_size  = sel_data ? data_size  : inst_size;
  assign bus_addr  = sel_data ? data_addr  : inst_addr;
  assign bus_wdata = sel_data ? data_wdata : inst_wdata;
  assign bus_cache = sel_data ? data_cache : inst_cache;

  assign inst_addr_ok = push && !sel_data;
  assign data_addr_ok = push &&  sel_data;
  assign inst_data_ok = pop  && !head;
  assign data_data_ok = pop  &&  head;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign arb_err      = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus_req && !bus_addr_ok) state_d = sel_data ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) begin
      id_d[wr_ptr_q] = sel_data;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (bus_data_ok && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter, checked against a queue-based model of grants and outstanding IDs.
module tb_sram_req_arbiter;

  localparam int unsigned DEPTH = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_cache, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_cache, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_cache, bus_addr_ok, bus_data_ok, arb_err;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  sram_req_arbiter #(.OUTST_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_cache(inst_cache), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_cache(data_cache), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_cache(bus_cache), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // model state: outstanding owners in issue order, held grant (-1 = none), last winner, sticky error
  int q[$];
  int held;
  bit last_win;
  bit err_m;

  // per-cycle results carried from the check point to the clock edge
  int owner_c;
  bit hs_c, ebreq_c, pop_c, stray_c;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    held     = -1;
    last_win = 1'b0;
    err_m    = 1'b0;
  endtask

  task automatic check_cycle();
    bit full;
    bit oreq;
    int owner;
    int head;
    logic [67:0] exp_f;
    full = (q.size() == DEPTH);
    if (held >= 0)                 owner = held;
    else if (RR && data_req && inst_req) owner = last_win ? 0 : 1;
    else                           owner = data_req ? 1 : 0;
    oreq    = (owner == 1) ? data_req : inst_req;
    ebreq_c = oreq && !full;
    hs_c    = ebreq_c && bus_addr_ok;
    owner_c = owner;
    exp_f = (owner == 1) ? {data_wr, data_size, data_addr, data_wdata, data_cache}
                         : {inst_wr, inst_size, inst_addr, inst_wdata, inst_cache};
    pop_c   = bus_data_ok && (q.size() > 0);
    stray_c = bus_data_ok && (q.size() == 0);
    head    = pop_c ? q[0] : -1;
    check_val("bus_req", bus_req, ebreq_c);
    check_val("bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata, bus_cache}, exp_f);
    check_val("addr_ok", {inst_addr_ok, data_addr_ok}, {hs_c && owner == 0, hs_c && owner == 1});
    check_val("data_ok", {inst_data_ok, data_data_ok}, {head == 0, head == 1});
    check_val("rdata", {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});
    check_val("arb_err", arb_err, err_m);
  endtask

  task automatic model_edge();
    if (pop_c) void'(q.pop_front());
    if (hs_c) begin
      q.push_back(owner_c);
      held     = -1;
      last_win = (owner_c == 1);
    end else if (held < 0 && ebreq_c) begin
      held = owner_c;
    end
    if (stray_c) err_m = 1'b1;
  endtask

  task automatic zero_inputs();
    inst_req = 0; inst_wr = 0; inst_size = '0; inst_addr = '0; inst_wdata = '0; inst_cache = 0;
    data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wdata = '0; data_cache = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    zero_inputs();
    model_clear();
    hs_c = 0;
    @(negedge clk);
    check_cycle();
    @(negedge clk);
    check_cycle();
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // requesters hold a request until accepted; after acceptance they drop or issue a fresh one
  task automatic drive(input int unsigned p_req, input int unsigned p_aok,
                       input int unsigned p_dok, input bit stray);
    bool_step_inst(hs_c && owner_c == 0, p_req);
    bool_step_data(hs_c && owner_c == 1, p_req);
    bus_addr_ok = ($urandom_range(99) < p_aok);
    bus_data_ok = (q.size() > 0 || stray) && ($urandom_range(99) < p_dok);
    bus_rdata   = $urandom;
  endtask

  task automatic bool_step_inst(input bit acc, input int unsigned p_req);
    if (!inst_req || acc) begin
      inst_req = ($urandom_range(99) < p_req);
      if (inst_req) begin
        inst_wr = 1'b0; inst_size = 2'($urandom_range(2)); inst_addr = $urandom;
        inst_wdata = $urandom; inst_cache = 1'($urandom);
      end
    end
  endtask

  task automatic bool_step_data(input bit acc, input int unsigned p_req);
    if (!data_req || acc) begin
      data_req = ($urandom_range(99) < p_req);
      if (data_req) begin
        data_wr = 1'($urandom); data_size = 2'($urandom_range(2)); data_addr = $urandom;
        data_wdata = $urandom; data_cache = 1'($urandom);
      end
    end
  endtask

  task automatic run_phase(input int n, input int unsigned p_req, input int unsigned p_aok,
                           input int unsigned p_dok, input bit stray);
    for (int i = 0; i < n; i++) begin
      drive(p_req, p_aok, p_dok, stray);
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    model_clear();
    do_reset();
    run_phase(300, 60, 70, 40, 1'b0);
    run_phase(300, 95, 85, 10, 1'b0);
    run_phase(200, 90, 25, 60, 1'b0);
    run_phase(100, 100, 100, 0, 1'b0);
    do_reset();
    run_phase(50, 70, 70, 50, 1'b0);
    run_phase(200, 50, 60, 60, 1'b1);
    do_reset();
    run_phase(200, 80, 60, 40, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
